mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have the following ports, one clock domain, listed clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- a  in  32  operand rs1
- b  in  32  operand rs2
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- flush  in  1  abandon any in-flight operation
- resp_valid  out  1  result present
- resp_ready  in  1  consumer takes result
- result  out  32  operation result
- zero_division  out  1  divisor was zero (op[2]=1 only)
- overflow_signed_div  out  1  DIV/REM with a=0x80000000, b=0xFFFFFFFF

Function
REQ-002 The block SHALL have states IDLE, CALC and DONE.
REQ-003 Handshake: a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; a response SHALL be consumed on a rising edge where resp_valid and resp_ready are both 1.
REQ-004 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in DONE.
REQ-005 a, b and op SHALL be captured on acceptance; later changes to those inputs SHALL have no effect on the in-flight operation.
REQ-006 Special cases SHALL go IDLE->DONE on the accept edge, so resp_valid=1 in the next cycle (latency 1):
- divide by zero: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> a, zero_division=1
- signed overflow: DIV -> 0x80000000, REM -> 0, overflow_signed_div=1
REQ-007 All other operations SHALL go IDLE->CALC and run exactly 32 iterations under a 5-bit counter, then CALC->DONE; resp_valid=1 exactly 33 cycles after the accept edge.
REQ-008 Multiply SHALL be radix-2 shift-add on operand magnitudes, giving a 64-bit product:
- MUL, MULH: both operands signed
- MULHSU: a signed, b unsigned
- MULHU: both unsigned
- the 64-bit product SHALL be two's-complement negated when the operand signs differ
- MUL returns product[31:0]; the other three return product[63:32]
REQ-009 Divide SHALL be radix-2 restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned):
- quotient is negated when the operand signs differ
- remainder takes the sign of a
- quotient rounds toward zero
REQ-010 In DONE, result and both flags SHALL hold stable until consumed; consumption SHALL move DONE->IDLE.
REQ-011 Both flags SHALL be 0 for every multiply and for every non-special division.
REQ-012 flush=1 SHALL force IDLE on the next edge from any state and drop any result. A flush in the same cycle as a valid request SHALL cause that request not to be accepted.
REQ-013 Back-to-back requests: the earliest next accept SHALL be the cycle after the consume edge (no overlap).

Reset
REQ-014 When rst=1 at a rising edge, the next state SHALL be IDLE regardless of state, including mid-CALC.
REQ-015 Reset values: req_ready=1, resp_valid=0, result=0x00000000, zero_division=0, overflow_signed_div=0, counter=0.
REQ-016 rst SHALL take priority over flush and over any handshake in the same cycle.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- MUL/MULH/MULHU with a=b=0xFFFFFFFF -> 0x00000001 / 0x00000000 / 0xFFFFFFFE; resp_valid 33 cycles after accept.
- MULHSU a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14.
- DIVU 7/0 -> 0xFFFFFFFF with zero_division=1; REM 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with overflow_signed_div=1. All three: resp_valid the cycle after accept.
- resp_ready held 0 for 5 cycles in DONE -> result and flags stable, req_ready=0; IDLE the cycle after resp_ready=1.
- flush asserted on cycle 10 of CALC -> IDLE next cycle, no resp_valid. rst mid-CALC -> all REQ-015 values the next cycle.
- Randomized operands against a golden model for all 8 ops -> zero mismatches.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies use radix-2 shift-add and divides use radix-2 restoring division,
// both on operand magnitudes, with the sign applied in a final cycle.
// Divide-by-zero and signed overflow bypass the iteration and answer on the accept edge.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   input  logic        flush,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] result,
   output logic        zero_division,
   output logic        overflow_signed_div
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  cnt_reg;
   logic        fin_reg;        // all 32 iterations done, next CALC cycle finalises
   logic [2:0]  op_reg;
   logic [31:0] mcand_reg;      // multiplicand magnitude, or divisor magnitude
   logic [31:0] hi_reg;         // product high half, or partial remainder
   logic [31:0] lo_reg;         // multiplier / product low half, or dividend / quotient
   logic        neg_res_reg;    // negate product or quotient
   logic        neg_rem_reg;    // negate remainder
   logic [31:0] result_reg;
   logic        zdiv_reg;
   logic        ovf_reg;

   // Request decode on the live inputs; only meaningful on the accept edge
   logic        accept;
   logic        a_signed, b_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic        div_zero, div_ovf;

   assign accept   = req_valid && (state_reg == IDLE) && !flush;
   assign a_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                     (op == 3'b100) || (op == 3'b110);
   assign b_signed = (op == 3'b000) || (op == 3'b001) ||
                     (op == 3'b100) || (op == 3'b110);
   assign a_neg    = a_signed && a[31];
   assign b_neg    = b_signed && b[31];
   assign a_mag    = a_neg ? (32'd0 - a) : a;
   assign b_mag    = b_neg ? (32'd0 - b) : b;
   assign div_zero = op[2] && (b == 32'd0);
   assign div_ovf  = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   // One iteration step of each algorithm
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [31:0] div_diff;
   logic        div_fits;

   assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : 33'd0);
   assign div_shift = {hi_reg, lo_reg[31]};
   assign div_fits  = div_shift >= {1'b0, mcand_reg};
   // The true difference is below 2^32 whenever it is used, so 32 bits suffice
   assign div_diff  = div_shift[31:0] - mcand_reg;

   // Sign correction and result selection once iteration is complete
   logic [63:0] prod_fixed;
   logic [31:0] quo_fixed, rem_fixed, final_result;

   assign prod_fixed = neg_res_reg ? (64'd0 - {hi_reg, lo_reg}) : {hi_reg, lo_reg};
   assign quo_fixed  = neg_res_reg ? (32'd0 - lo_reg) : lo_reg;
   assign rem_fixed  = neg_rem_reg ? (32'd0 - hi_reg) : hi_reg;

   // Pick the slice or quotient/remainder that the captured op asks for
   always_comb begin
      final_result = 32'd0;
      if (op_reg[2]) begin
         final_result = op_reg[1] ? rem_fixed : quo_fixed;
      end else begin
         final_result = (op_reg[1:0] == 2'b00) ? prod_fixed[31:0] : prod_fixed[63:32];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = (div_zero || div_ovf) ? DONE : CALC;
         CALC: if (fin_reg) state_next = DONE;
         DONE: if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   // Operand capture, iteration datapath and result/flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= 5'd0;
         fin_reg     <= 1'b0;
         op_reg      <= 3'd0;
         mcand_reg   <= 32'd0;
         hi_reg      <= 32'd0;
         lo_reg      <= 32'd0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         result_reg  <= 32'd0;
         zdiv_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
      end else if (flush) begin
         cnt_reg    <= 5'd0;
         fin_reg    <= 1'b0;
         result_reg <= 32'd0;
         zdiv_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg      <= op;
                  cnt_reg     <= 5'd0;
                  fin_reg     <= 1'b0;
                  zdiv_reg    <= div_zero;
                  ovf_reg     <= div_ovf;
                  neg_res_reg <= a_neg ^ b_neg;
                  neg_rem_reg <= a_neg;
                  hi_reg      <= 32'd0;
                  if (op[2]) begin
                     lo_reg    <= a_mag;
                     mcand_reg <= b_mag;
                  end else begin
                     lo_reg    <= b_mag;
                     mcand_reg <= a_mag;
                  end
                  if (div_zero) begin
                     result_reg <= op[1] ? a : 32'hFFFF_FFFF;
                  end else if (div_ovf) begin
                     result_reg <= op[1] ? 32'd0 : 32'h8000_0000;
                  end
               end
            end
            CALC: begin
               if (fin_reg) begin
                  result_reg <= final_result;
               end else begin
                  if (op_reg[2]) begin
                     hi_reg <= div_fits ? div_diff : div_shift[31:0];
                     lo_reg <= {lo_reg[30:0], div_fits};
                  end else begin
                     {hi_reg, lo_reg} <= {mul_sum, lo_reg[31:1]};
                  end
                  cnt_reg <= cnt_reg + 5'd1;
                  if (cnt_reg == 5'd31) begin
                     fin_reg <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign req_ready           = (state_reg == IDLE);
   assign resp_valid          = (state_reg == DONE);
   assign result              = result_reg;
   assign zero_division       = zdiv_reg;
   assign overflow_signed_div = ovf_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, handshake/flush/reset
// sequences, and randomized operations against an arithmetic reference model.
// Latency is counted as rising edges after the accept edge until resp_valid is seen.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, flush;
   logic        resp_valid, resp_ready, zero_division, overflow_signed_div;
   logic [31:0] a, b, result;
   logic [2:0]  op;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .a                   (a),
      .b                   (b),
      .op                  (op),
      .flush               (flush),
      .resp_valid          (resp_valid),
      .resp_ready          (resp_ready),
      .result              (result),
      .zero_division       (zero_division),
      .overflow_signed_div (overflow_signed_div)
   );

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [2:0]  vop;
      logic [31:0] exp_r;
      logic        exp_zd;
      logic        exp_ov;
      int          exp_lat;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit products and SV integer division / modulo
   function automatic void ref_op(input logic [31:0] ra, input logic [31:0] rb,
                                  input logic [2:0] rop, output logic [31:0] r,
                                  output logic zd, output logic ov, output int lat);
      logic [63:0] sa, sb, ua, ub, p;
      int          si, sj;
      sa  = {{32{ra[31]}}, ra};
      sb  = {{32{rb[31]}}, rb};
      ua  = {32'd0, ra};
      ub  = {32'd0, rb};
      si  = ra;
      sj  = rb;
      zd  = 1'b0;
      ov  = 1'b0;
      lat = 33;
      r   = 32'd0;
      p   = 64'd0;
      case (rop)
         3'd0: begin p = sa * sb; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         default: begin
            if (rb == 32'd0) begin
               zd  = 1'b1;
               lat = 0;
               r   = rop[1] ? ra : 32'hFFFF_FFFF;
            end else if (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) begin
               ov  = 1'b1;
               lat = 0;
               r   = rop[1] ? 32'd0 : 32'h8000_0000;
            end else begin
               case (rop)
                  3'd4:    r = si / sj;
                  3'd5:    r = ra / rb;
                  3'd6:    r = si % sj;
                  default: r = ra % rb;
               endcase
            end
         end
      endcase
   endfunction

   // Present a request for one cycle, then scramble the operand inputs
   task automatic start_op(input logic [31:0] ta, input logic [31:0] tb2, input logic [2:0] top);
      @(negedge clk);
      a = ta; b = tb2; op = top; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom);
   endtask

   // Count edges after the accept edge until resp_valid; -1 if it never comes
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!resp_valid) lat = -1;
   endtask

   task automatic consume();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   task automatic run_check(input string name, input logic [31:0] ta, input logic [31:0] tb2,
                            input logic [2:0] top, input logic [31:0] er, input logic ezd,
                            input logic eov, input int elat);
      int lat;
      start_op(ta, tb2, top);
      wait_resp(lat);
      $display("%s: a=%h b=%h op=%0d result=%h zd=%0b ov=%0b lat=%0d", name, ta, tb2, top,
               result, zero_division, overflow_signed_div, lat);
      check({name, " result"}, 64'(result), 64'(er));
      check({name, " zero_division"}, 64'(zero_division), 64'(ezd));
      check({name, " overflow"}, 64'(overflow_signed_div), 64'(eov));
      check({name, " latency"}, 64'(lat), 64'(elat));
      consume();
      check({name, " idle after consume"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      int          lat, seen;
      logic [31:0] ra, rb, er;
      logic [2:0]  rop;
      logic        ezd, eov;
      int          elat;

      vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 32'h0000_0001, 1'b0, 1'b0, 33};
      vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0000, 1'b0, 1'b0, 33};
      vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, 33};
      vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0002, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
      vecs[4]  = '{32'hFFFF_FFF9, 32'h0000_0002, 3'd4, 32'hFFFF_FFFD, 1'b0, 1'b0, 33};
      vecs[5]  = '{32'hFFFF_FFF9, 32'h0000_0002, 3'd6, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
      vecs[6]  = '{32'd100,       32'd7,         3'd5, 32'd14,        1'b0, 1'b0, 33};
      vecs[7]  = '{32'd7,         32'd0,         3'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 0};
      vecs[8]  = '{32'd7,         32'd0,         3'd6, 32'd7,         1'b1, 1'b0, 0};
      vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h8000_0000, 1'b0, 1'b1, 0};
      vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 1'b0, 1'b1, 0};
      vecs[11] = '{32'h8000_0000, 32'h8000_0000, 3'd1, 32'h4000_0000, 1'b0, 1'b0, 33};

      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
      a = 32'd0; b = 32'd0; op = 3'd0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      $display("reset: req_ready=%0b resp_valid=%0b result=%h", req_ready, resp_valid, result);
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset resp_valid", 64'(resp_valid), 64'd0);
      check("reset result", 64'(result), 64'd0);
      check("reset zero_division", 64'(zero_division), 64'd0);
      check("reset overflow", 64'(overflow_signed_div), 64'd0);
      check("reset counter", 64'(dut.cnt_reg), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vop,
                   vecs[i].exp_r, vecs[i].exp_zd, vecs[i].exp_ov, vecs[i].exp_lat);
      end

      // Hold the response for 5 cycles: everything stays put
      start_op(32'd7, 32'd0, 3'd5);
      wait_resp(lat);
      check("stall latency", 64'(lat), 64'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         $display("stall cycle %0d: resp_valid=%0b req_ready=%0b result=%h zd=%0b",
                  k, resp_valid, req_ready, result, zero_division);
         check("stall resp_valid", 64'(resp_valid), 64'd1);
         check("stall req_ready", 64'(req_ready), 64'd0);
         check("stall result", 64'(result), 64'hFFFF_FFFF);
         check("stall zero_division", 64'(zero_division), 64'd1);
         check("stall overflow", 64'(overflow_signed_div), 64'd0);
      end
      consume();
      $display("stall consumed: req_ready=%0b resp_valid=%0b", req_ready, resp_valid);
      check("stall consumed req_ready", 64'(req_ready), 64'd1);
      check("stall consumed resp_valid", 64'(resp_valid), 64'd0);

      // Reset in the middle of CALC
      start_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd3);
      repeat (15) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      $display("rst mid-calc: req_ready=%0b resp_valid=%0b result=%h", req_ready, resp_valid, result);
      check("rst mid-calc req_ready", 64'(req_ready), 64'd1);
      check("rst mid-calc resp_valid", 64'(resp_valid), 64'd0);
      check("rst mid-calc result", 64'(result), 64'd0);
      check("rst mid-calc zero_division", 64'(zero_division), 64'd0);
      check("rst mid-calc overflow", 64'(overflow_signed_div), 64'd0);
      check("rst mid-calc counter", 64'(dut.cnt_reg), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset wins over flush and a request in the same cycle
      @(negedge clk);
      rst = 1'b1; flush = 1'b1; req_valid = 1'b1; a = 32'd7; b = 32'd0; op = 3'd5;
      @(posedge clk);
      #1;
      rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
      $display("rst+req: resp_valid=%0b req_ready=%0b", resp_valid, req_ready);
      check("rst priority resp_valid", 64'(resp_valid), 64'd0);
      check("rst priority req_ready", 64'(req_ready), 64'd1);

      // Flush on cycle 10 of CALC
      start_op(32'hDEAD_BEEF, 32'h0000_1234, 3'd0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      $display("flush mid-calc: req_ready=%0b resp_valid=%0b", req_ready, resp_valid);
      check("flush req_ready", 64'(req_ready), 64'd1);
      check("flush resp_valid", 64'(resp_valid), 64'd0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (resp_valid) seen++;
      end
      check("flush no late response", 64'(seen), 64'd0);

      // Flush together with a request: not accepted
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; a = 32'd7; b = 32'd0; op = 3'd5;
      @(posedge clk);
      #1;
      flush = 1'b0; req_valid = 1'b0;
      $display("flush+req: resp_valid=%0b req_ready=%0b", resp_valid, req_ready);
      check("flush blocks accept", 64'(resp_valid), 64'd0);

      // Randomized operations against the reference model
      for (int i = 0; i < 200; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(1, 15);
            3: ra = $urandom_range(0, 255);
            default: ;
         endcase
         ref_op(ra, rb, rop, er, ezd, eov, elat);
         run_check($sformatf("rand%0d", i), ra, rb, rop, er, ezd, eov, elat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
